td4_prog_loader: RTL and testbench

TD4_PROG_LOADER -- requirements
Module: td4_prog_loader

---
 rtl/td4_prog_loader.sv | 113 +++++++++++
 tb/tb_td4_prog_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// Serial program loader for a TD4-style CPU: receives a framed program over a
// valid/ready byte stream, stores it in a 16x8 instruction memory and releases the CPU once the checksum matches.
module td4_prog_loader #(
  parameter logic [7:0] SYNC = 8'hA5
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  output logic       IN_READY,
  input  logic [3:0] Address,
  output logic [7:0] Order,
  output logic       CPU_HOLD,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_LOADED,
    S_ERROR
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  ptr_reg;
  logic [4:0]  remaining_reg;
  logic [7:0]  sum_reg;
  logic        done_reg;
  logic        err_reg;
  logic        hold_reg;
  logic        ready_reg;

  logic [7:0]  mem_reg [16];

  logic        xfer;
  logic        count_ok;
  logic        clear_all;
  logic        wr_en;

  assign xfer      = IN_VALID & ready_reg;
  assign count_ok  = (IN_DATA != 8'd0) && (IN_DATA <= 8'd16);
  assign clear_all = xfer && (state_reg == S_COUNT) && count_ok;
  assign wr_en     = xfer && (state_reg == S_DATA);

  always_comb begin
    state_next = state_reg;
    if (xfer) begin
      case (state_reg)
        S_IDLE:   if (IN_DATA == SYNC) state_next = S_COUNT;
        S_COUNT:  state_next = count_ok ? S_DATA : S_ERROR;
        S_DATA:   if (remaining_reg == 5'd1) state_next = S_CHECK;
        S_CHECK:  state_next = (IN_DATA == sum_reg) ? S_LOADED : S_ERROR;
        S_LOADED: state_next = S_LOADED;
        S_ERROR:  if (IN_DATA == SYNC) state_next = S_COUNT;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they are registered
  // alongside state_reg and never see IN_VALID/IN_DATA combinationally.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= 4'd0;
      remaining_reg <= 5'd0;
      sum_reg       <= 8'd0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      hold_reg      <= 1'b1;
      ready_reg     <= 1'b1;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_next == S_LOADED);
      err_reg   <= (state_next == S_ERROR);
      hold_reg  <= (state_next != S_LOADED);
      ready_reg <= (state_next != S_LOADED);
      if (clear_all) begin
        remaining_reg <= IN_DATA[4:0];
        ptr_reg       <= 4'd0;
        sum_reg       <= 8'd0;
      end else if (wr_en) begin
        ptr_reg       <= ptr_reg + 4'd1;
        sum_reg       <= sum_reg + IN_DATA;
        remaining_reg <= remaining_reg - 5'd1;
      end
    end
  end

  // Memory is held in flops: it must clear all words in one edge and be read with zero latency.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mem
      always_ff @(posedge CLK) begin
        if (CLR || clear_all) begin
          mem_reg[gi] <= 8'h00;
        end else if (wr_en && (ptr_reg == 4'(gi))) begin
          mem_reg[gi] <= IN_DATA;
        end
      end
    end
  endgenerate

  assign Order    = mem_reg[Address];
  assign IN_READY = ready_reg;
  assign CPU_HOLD = hold_reg;
  assign DONE     = done_reg;
  assign ERR      = err_reg;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: frames, checksum and count errors,
// backpressure, and reset behaviour, each checked against hand-computed values.
module tb_td4_prog_loader;

  logic       CLK;
  logic       CLR;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY;
  logic [3:0] Address;
  logic [7:0] Order;
  logic       CPU_HOLD;
  logic       DONE;
  logic       ERR;

  int checks;
  int errors;

  td4_prog_loader #(.SYNC(8'hA5)) dut (
    .CLK(CLK),
    .CLR(CLR),
    .IN_VALID(IN_VALID),
    .IN_DATA(IN_DATA),
    .IN_READY(IN_READY),
    .Address(Address),
    .Order(Order),
    .CPU_HOLD(CPU_HOLD),
    .DONE(DONE),
    .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one valid byte for a single edge; returns #1 after that edge.
  task automatic send(input logic [7:0] b);
    IN_VALID = 1'b1;
    IN_DATA  = b;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    $display("xfer byte %02h -> done=%0b err=%0b hold=%0b ready=%0b", b, DONE, ERR, CPU_HOLD, IN_READY);
  endtask

  task automatic idle_cycle(input logic [7:0] junk);
    IN_VALID = 1'b0;
    IN_DATA  = junk;
    @(posedge CLK);
    #1;
    $display("idle cycle data %02h (valid=0)", junk);
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    $display("clr pulse -> done=%0b err=%0b hold=%0b ready=%0b", DONE, ERR, CPU_HOLD, IN_READY);
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                              input logic exp_hold, input logic exp_ready);
    checks++;
    if ({DONE, ERR, CPU_HOLD, IN_READY} !== {exp_done, exp_err, exp_hold, exp_ready}) begin
      errors++;
      $display("FAIL %s: got done/err/hold/ready=%b expected %b", name,
               {DONE, ERR, CPU_HOLD, IN_READY}, {exp_done, exp_err, exp_hold, exp_ready});
    end
  endtask

  task automatic check_order(input string name, input logic [3:0] a, input logic [7:0] exp);
    Address = a;
    #1;
    checks++;
    if (Order !== exp) begin
      errors++;
      $display("FAIL %s: Order[%0d] got %02h expected %02h", name, a, Order, exp);
    end
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    IN_VALID = 1'b0;
    IN_DATA = 8'h00;
    Address = 4'd0;
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;
    check_status("reset_status", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) check_order("reset_mem", 4'(i), 8'h00);
  endtask

  task automatic test_good_frame();
    pulse_clr();
    send(8'hA5); send(8'h03); send(8'hB1); send(8'h01); send(8'hE0);
    check_status("good_before_sum", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h92);
    check_status("good_loaded", 1'b1, 1'b0, 1'b0, 1'b0);
    check_order("good_mem0", 4'd0, 8'hB1);
    check_order("good_mem1", 4'd1, 8'h01);
    check_order("good_mem2", 4'd2, 8'hE0);
    check_order("good_mem3", 4'd3, 8'h00);
    check_order("good_mem15", 4'd15, 8'h00);
  endtask

  task automatic test_bad_checksum();
    pulse_clr();
    send(8'hA5); send(8'h02); send(8'h30); send(8'h40); send(8'h71);
    check_status("badsum_err", 1'b0, 1'b1, 1'b1, 1'b1);
    check_order("badsum_mem0_kept", 4'd0, 8'h30);
    check_order("badsum_mem1_kept", 4'd1, 8'h40);
    send(8'hA5);
    check_status("badsum_resync", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h01); send(8'hF0); send(8'hF0);
    check_status("badsum_reload", 1'b1, 1'b0, 1'b0, 1'b0);
    check_order("badsum_reload_mem0", 4'd0, 8'hF0);
    check_order("badsum_reload_mem1", 4'd1, 8'h00);
  endtask

  task automatic test_count_errors();
    pulse_clr();
    // Bad checksum leaves 11,22 in memory and parks the loader in ERROR.
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h00);
    check_status("cnt_setup_err", 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'hA5); send(8'h00);
    check_status("cnt_zero_err", 1'b0, 1'b1, 1'b1, 1'b1);
    check_order("cnt_zero_mem0", 4'd0, 8'h11);
    check_order("cnt_zero_mem1", 4'd1, 8'h22);
    send(8'hA5); send(8'h11);
    check_status("cnt_big_err", 1'b0, 1'b1, 1'b1, 1'b1);
    check_order("cnt_big_mem0", 4'd0, 8'h11);
    check_order("cnt_big_mem1", 4'd1, 8'h22);
    send(8'h10);
    check_status("cnt_err_discard", 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    logic [7:0] seq [6];
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h05, 8'h05};
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      idle_cycle(8'hA5);
      send(seq[i]);
    end
    check_status("bp_loaded", 1'b1, 1'b0, 1'b0, 1'b0);
    check_order("bp_mem0", 4'd0, 8'h05);
    check_order("bp_mem1", 4'd1, 8'h00);
    send(8'hA5); send(8'h01); send(8'h77);
    check_status("bp_hold_loaded", 1'b1, 1'b0, 1'b0, 1'b0);
    check_order("bp_mem0_kept", 4'd0, 8'h05);
    check_order("bp_mem1_kept", 4'd1, 8'h00);
  endtask

  task automatic test_reset_midframe();
    pulse_clr();
    send(8'hA5); send(8'h04); send(8'h11);
    check_order("mid_mem0_written", 4'd0, 8'h11);
    pulse_clr();
    check_status("mid_clr_status", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) check_order("mid_clr_mem", 4'(i), 8'h00);
    // CLR and a valid SYNC on the same edge: the byte must be dropped.
    CLR = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = 8'hA5;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    IN_VALID = 1'b0;
    check_status("mid_clr_priority", 1'b0, 1'b0, 1'b1, 1'b1);
    // Stray count byte: discarded in IDLE, would open a 2-byte frame if SYNC had been taken.
    send(8'h02);
    send(8'hA5);
    send(8'h10);
    for (int i = 0; i < 16; i++) send(8'hF0 + 8'(i));
    check_status("full_before_sum", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h78);
    check_status("full_loaded", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check_order("full_mem", 4'(i), 8'hF0 + 8'(i));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    CLR = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA = 8'h00;
    Address = 4'd0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_count_errors();
    test_backpressure();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
